adc_frame_capture: RTL and testbench
====================================

ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, frame length in samples; must be a power of two.
REQ-002 SHALL have parameter AW, default 10, write-address width, log2(DEPTH).
REQ-003 SHALL have port clk_w  input  1  capture clock; all logic synchronous to its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_raw  input  12  unsigned ADC sample, new value every clk_w.
REQ-006 SHALL have port adc_otr  input  1  ADC out-of-range flag, aligned with adc_raw.
REQ-007 SHALL have port cmd_valid  input  1  command strobe, one clk_w cycle per command.
REQ-008 SHALL have port cmd  input  16  command code, valid while cmd_valid=1.
REQ-009 SHALL have port trig_level  input  12  trigger threshold, quasi-static.
REQ-010 SHALL have port trig_mode  input  1  0 = rising-edge trigger, 1 = immediate trigger.
REQ-011 SHALL have port decim  input  8  decimation; store one of every decim+1 samples.
REQ-012 SHALL have port wr_en  output  1  buffer write strobe.
REQ-013 SHALL have port wr_addr  output  AW  buffer write address.
REQ-014 SHALL have port wr_data  output  16  buffer write data.
REQ-015 SHALL have port busy  output  1  high in ARMED or CAPTURE.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when a frame is complete.
REQ-017 SHALL have port otr_seen  output  1  sticky: a stored sample had adc_otr=1.

Function
REQ-018 SHALL register adc_raw/adc_otr every cycle into cur, and cur into prev.
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-020 SHALL decode ARM = 0x00A1 and ABORT = 0x00A0; all other codes are ignored.
REQ-021 IDLE: ARM -> ARMED, clear otr_seen, zero the address and decimation counters; ARM in any other state is ignored.
REQ-022 ARMED, trig_mode=0: trigger when prev < trig_level and cur >= trig_level (unsigned compare).
REQ-023 ARMED, trig_mode=1: trigger on the first cycle in ARMED.
REQ-024 On trigger: state -> CAPTURE; the triggering cur sample is stored as address 0.
REQ-025 Storing a sample: registered wr_en=1 for one cycle, wr_data = {cur_otr, 3'b000, cur[11:0]}, wr_addr = address counter; latency from adc_raw input to wr_en is 2 clk_w cycles.
REQ-026 CAPTURE: after each stored sample, skip exactly decim samples before storing the next; decim=0 stores every cycle.
REQ-027 Address increments by 1 per stored sample and never wraps; storing address DEPTH-1 causes state -> DONE.
REQ-028 DONE: frame_done=1 for exactly one cycle, then -> IDLE; busy=0 in DONE.
REQ-029 otr_seen SHALL set on any stored sample with adc_otr=1 and hold until the next ARM or reset.
REQ-030 ABORT in any state -> IDLE on that edge: no further wr_en, no frame_done, otr_seen retained.
REQ-031 Simultaneous ABORT and trigger, or ABORT and final store: ABORT wins, with no write and no frame_done in that cycle.
REQ-032 wr_en=0 in IDLE, ARMED and DONE, and during skipped decimation cycles.
REQ-033 Changes to decim or trig_mode while busy are undefined; the bench must not do this.

Reset
REQ-034 On rst=0: state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, otr_seen=0; prev=0, cur=0, all counters 0.
REQ-035 Reset mid-capture SHALL abandon the frame immediately, with no frame_done after release.
REQ-036 After rst deasserts, the first ARM SHALL be accepted on the first clk_w edge.

Verification
REQ-037 Ramp adc_raw 0..4095 +1/cycle, trig_level=100, mode 0, decim 0, ARM -> first wr_en with wr_data=0x0064 at addr 0; 1024 consecutive writes; last is 0x0463 at addr 1023; one frame_done pulse.
REQ-038 Mode 1, decim 3, ramp -> writes every 4th cycle, successive wr_data differ by 4; frame_done after 1024 writes (~4093 cycles).
REQ-039 ARM, trigger, ABORT after 10 writes -> wr_en stops the next cycle, busy=0, no frame_done; a new ARM restarts at addr 0.
REQ-040 adc_otr=1 on one stored sample -> that wr_data[15]=1 and otr_seen=1 until the next ARM.
REQ-041 Constant adc_raw=200, trig_level=100, mode 0 -> no trigger; busy stays 1 with no writes; ABORT returns to IDLE.
REQ-042 rst pulse at addr 500 -> all outputs 0 immediately, no frame_done; a subsequent ARM completes a full frame.

Source files
------------

// File: rtl/adc_frame_capture_if.sv
// Sample, command, configuration and buffer-write signals of the ADC frame capture block.
// The master side drives samples/commands and receives buffer writes; the slave side is the capture engine.
interface adc_frame_capture_if #(
  parameter int AW = 10
);
  logic [11:0]   adc_raw;
  logic          adc_otr;
  logic          cmd_valid;
  logic [15:0]   cmd;
  logic [11:0]   trig_level;
  logic          trig_mode;
  logic [7:0]    decim;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          otr_seen;

  modport master (
    output adc_raw, adc_otr, cmd_valid, cmd, trig_level, trig_mode, decim,
    input  wr_en, wr_addr, wr_data, busy, frame_done, otr_seen
  );

  modport slave (
    input  adc_raw, adc_otr, cmd_valid, cmd, trig_level, trig_mode, decim,
    output wr_en, wr_addr, wr_data, busy, frame_done, otr_seen
  );
endinterface

// File: rtl/adc_frame_capture.sv
// Triggered, decimated capture of one DEPTH-sample ADC frame into an external write-only buffer.
//
//   state   | meaning
//   IDLE    | waiting for ARM
//   ARMED   | waiting for trigger (edge crossing or immediate)
//   CAPTURE | storing one of every decim+1 samples
//   DONE    | frame complete, frame_done pulses for one cycle
module adc_frame_capture #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic clk_w,
  input logic rst,
  adc_frame_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [15:0]   CMD_ARM   = 16'h00A1;
  localparam logic [15:0]   CMD_ABORT = 16'h00A0;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [11:0]   cur_q, prev_q;
  logic          cur_otr_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    skip_q, skip_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          otr_seen_q, otr_seen_d;
  logic          cmd_arm, cmd_abort, trig, store;

  assign cmd_arm   = bus.cmd_valid && (bus.cmd == CMD_ARM);
  assign cmd_abort = bus.cmd_valid && (bus.cmd == CMD_ABORT);
  assign trig      = bus.trig_mode ||
                     ((prev_q < bus.trig_level) && (cur_q >= bus.trig_level));

  always_ff @(posedge clk_w or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      prev_q     <= '0;
      cur_otr_q  <= 1'b0;
      addr_q     <= '0;
      skip_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      otr_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= bus.adc_raw;
      prev_q     <= cur_q;
      cur_otr_q  <= bus.adc_otr;
      addr_q     <= addr_d;
      skip_q     <= skip_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      otr_seen_q <= otr_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    skip_d     = skip_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    otr_seen_d = otr_seen_q;
    store      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_arm) begin
          state_d    = ARMED;
          otr_seen_d = 1'b0;
          addr_d     = '0;
          skip_d     = '0;
        end
      end
      ARMED: store = trig;
      CAPTURE: begin
        if (skip_q != 8'd0) skip_d = skip_q - 8'd1;
        else                store  = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort beats both the trigger store and the final store of a frame.
    if (cmd_abort) begin
      state_d = IDLE;
    end else if (store) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = addr_q;
      wr_data_d  = {cur_otr_q, 3'b000, cur_q};
      otr_seen_d = otr_seen_q | cur_otr_q;
      skip_d     = bus.decim;
      if (addr_q == LAST_ADDR) begin
        state_d = DONE;
      end else begin
        state_d = CAPTURE;
        addr_d  = addr_q + AW'(1);
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.otr_seen   = otr_seen_q;
  assign bus.busy       = (state_q == ARMED) || (state_q == CAPTURE);
  assign bus.frame_done = (state_q == DONE);
endmodule

// File: tb/tb_adc_frame_capture.sv
// Scoreboard bench for adc_frame_capture: a sample-history reference model predicts every buffer write,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_adc_frame_capture;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int MAXN  = 8192;

  typedef struct packed {
    logic [15:0]   d;
    logic [AW-1:0] a;
  } wr_t;

  logic clk_w = 1'b0;
  logic rst   = 1'b0;
  always #5 clk_w = ~clk_w;

  adc_frame_capture_if #(.AW(AW)) ifc ();
  adc_frame_capture #(.DEPTH(DEPTH), .AW(AW)) dut (.clk_w(clk_w), .rst(rst), .bus(ifc));

  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [11:0] samp [0:MAXN-1];
  logic        otrv [0:MAXN-1];
  bit   m_otr  = 1'b0;
  bit   m_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the oldest predicted write.
  always @(negedge clk_w) begin
    if (rst) begin
      if (ifc.frame_done) fd_cnt++;
      if (ifc.wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write at %0t",
                   ifc.wr_addr, ifc.wr_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(ifc.wr_addr), 32'(mon_e.a));
          chk("wr_data", 32'(ifc.wr_data), 32'(mon_e.d));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"},      32'(ifc.wr_en),      0);
    chk({tag, "_wr_addr"},    32'(ifc.wr_addr),    0);
    chk({tag, "_wr_data"},    32'(ifc.wr_data),    0);
    chk({tag, "_busy"},       32'(ifc.busy),       0);
    chk({tag, "_frame_done"}, 32'(ifc.frame_done), 0);
    chk({tag, "_otr_seen"},   32'(ifc.otr_seen),   0);
  endtask

  task automatic fill_ramp(input int start);
    for (int t = 0; t < MAXN; t++) begin
      samp[t] = 12'(start + t);
      otrv[t] = 1'b0;
    end
  endtask

  task automatic fill_const(input logic [11:0] v);
    for (int t = 0; t < MAXN; t++) begin
      samp[t] = v;
      otrv[t] = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int t = 0; t < MAXN; t++) begin
      samp[t] = 12'($urandom_range(0, 4095));
      otrv[t] = ($urandom_range(0, 199) == 0);
    end
  endtask

  function automatic logic [15:0] noise_code();
    logic [15:0] c;
    do c = 16'($urandom); while (c == 16'h00A0 || c == 16'h00A1);
    return c;
  endfunction

  // Runs n input cycles; cycle t is sampled at clock edge t. ARM at edge a (a<0: none),
  // ABORT (or reset pulse when is_rst) at edge b (b<0: none).
  task automatic run(input string nm, input int n, input int a, input int b, input bit is_rst,
                     input bit mode, input logic [7:0] dec, input logic [11:0] lvl, input bit noise);
    int  j, eff, idx, e;
    bit  exp_done, exp_busy;
    wr_t w;
    eff = n - 1;
    if (b >= 0 && b < eff) eff = b;
    j = -1;
    if (a >= 0) begin
      m_otr = 1'b0;
      if (mode) begin
        if (a + 1 < eff) j = a;
      end else begin
        for (int t = (a > 0 ? a : 1); t + 1 < eff; t++)
          if (samp[t-1] < lvl && samp[t] >= lvl) begin
            j = t;
            break;
          end
      end
    end
    exp_done = 1'b0;
    if (j >= 0)
      for (int k = 0; k < DEPTH; k++) begin
        idx = j + k * (int'(dec) + 1);
        e   = idx + 1;
        if (e >= eff) break;
        w.d = {otrv[idx], 3'b000, samp[idx]};
        w.a = AW'(k);
        exp_q.push_back(w);
        m_otr = m_otr | otrv[idx];
        if (k == DEPTH - 1) exp_done = 1'b1;
      end
    if (b >= 0 && b < n)  exp_busy = 1'b0;
    else if (exp_done)    exp_busy = 1'b0;
    else if (a >= 0)      exp_busy = 1'b1;
    else                  exp_busy = m_busy;
    if (is_rst) m_otr = 1'b0;

    ifc.trig_mode  = mode;
    ifc.decim      = dec;
    ifc.trig_level = lvl;
    fd_cnt = 0;
    for (int t = 0; t < n; t++) begin
      ifc.adc_raw   = samp[t];
      ifc.adc_otr   = otrv[t];
      ifc.cmd_valid = 1'b0;
      ifc.cmd       = 16'($urandom);
      if (t == a) begin
        ifc.cmd_valid = 1'b1;
        ifc.cmd       = 16'h00A1;
      end else if (t == b && !is_rst) begin
        ifc.cmd_valid = 1'b1;
        ifc.cmd       = 16'h00A0;
      end else if (noise && $urandom_range(0, 39) == 0) begin
        ifc.cmd_valid = 1'b1;
        ifc.cmd       = noise_code();
      end
      if (is_rst && t == b) begin
        #6;
        rst = 1'b0;
        #1;
        check_all_zero({nm, "_midrst"});
      end
      @(posedge clk_w);
      #1;
    end
    ifc.cmd_valid = 1'b0;

    chk({nm, "_writes_outstanding"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    chk({nm, "_frame_done_pulses"}, 32'(fd_cnt), 32'(exp_done));
    chk({nm, "_otr_seen"}, 32'(ifc.otr_seen), 32'(m_otr));
    chk({nm, "_busy"}, 32'(ifc.busy), 32'(exp_busy));
    m_busy = exp_busy;
  endtask

  initial begin
    int a, b, n;
    logic [7:0] dec;
    ifc.adc_raw    = '0;
    ifc.adc_otr    = 1'b0;
    ifc.cmd_valid  = 1'b0;
    ifc.cmd        = '0;
    ifc.trig_level = '0;
    ifc.trig_mode  = 1'b0;
    ifc.decim      = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk_w);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Ramp, edge trigger at 100: first write 0x064 at 0, last 0x463 at 1023.
    fill_ramp(0);
    run("ramp_mode0", 1135, 2, -1, 1'b0, 1'b0, 8'd0, 12'd100, 1'b0);

    // Immediate trigger, decimate by 4.
    fill_ramp(0);
    run("ramp_decim3", 4100, 2, -1, 1'b0, 1'b1, 8'd3, 12'd100, 1'b0);

    // Abort after 10 writes.
    fill_ramp(0);
    run("abort10", 70, 2, 61, 1'b0, 1'b0, 8'd0, 12'd50, 1'b0);

    // Fresh ARM restarts at address 0; one out-of-range sample gets stored.
    fill_ramp(7);
    otrv[300] = 1'b1;
    run("otr_frame", 1031, 2, -1, 1'b0, 1'b1, 8'd0, 12'd0, 1'b0);
    fill_ramp(0);
    run("otr_hold", 5, -1, -1, 1'b0, 1'b0, 8'd0, 12'd0, 1'b1);

    // Constant above threshold never crosses it.
    fill_const(12'd200);
    run("no_trig", 60, 2, -1, 1'b0, 1'b0, 8'd0, 12'd100, 1'b1);
    run("no_trig_abort", 6, -1, 3, 1'b0, 1'b0, 8'd0, 12'd100, 1'b0);

    // Reset right after the write to address 500, then ARM on the first edge after release.
    fill_ramp(0);
    run("rst500", 506, 2, 504, 1'b1, 1'b1, 8'd0, 12'd0, 1'b0);
    rst = 1'b1;
    m_busy = 1'b0;
    fill_ramp(0);
    run("after_rst", 1030, 0, -1, 1'b0, 1'b1, 8'd0, 12'd0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      fill_random();
      dec = 8'($urandom_range(0, 2));
      a   = $urandom_range(2, 5);
      n   = a + (int'(dec) + 1) * DEPTH + 300;
      b   = (i % 2 == 1) ? a + $urandom_range(10, 2000) : n - 2;
      run("random", n, a, b, 1'b0, 1'(i % 2 == 0 ? $urandom_range(0, 1) : 0), dec,
          12'($urandom_range(1000, 3000)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
